// File: rtl/pipe_skid_buffer.sv
// Two-entry valid/ready skid buffer between ARM pipeline stages.
// All outputs decode from the state register, so ready_in never reaches ready_out combinationally.
module pipe_skid_buffer #(
   parameter int BUS_WIDTH = 32
) (
   input  logic                 clk_in,
   input  logic                 reset_n_in,
   input  logic [BUS_WIDTH-1:0] data_in,
   input  logic                 valid_in,
   output logic                 ready_out,
   output logic [BUS_WIDTH-1:0] data_out,
   output logic                 valid_out,
   input  logic                 ready_in,
   input  logic                 flush_in,
   output logic [1:0]           occupancy_out
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t               state;
   logic [BUS_WIDTH-1:0] main_q;
   logic [BUS_WIDTH-1:0] skid_q;
   logic                 accept;
   logic                 take;

   assign valid_out = (state != EMPTY);
   assign ready_out = (state != FULL);
   assign data_out  = main_q;
   assign accept    = valid_in & ready_out;
   assign take      = valid_out & ready_in;

   always_comb begin
      occupancy_out = 2'd0;
      case (state)
         BUSY:    occupancy_out = 2'd1;
         FULL:    occupancy_out = 2'd2;
         default: occupancy_out = 2'd0;
      endcase
   end

   // Flush outranks both handshakes; a take in the flush cycle still completes downstream.
   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         state  <= EMPTY;
         main_q <= '0;
         skid_q <= '0;
      end else if (flush_in) begin
         state  <= EMPTY;
         main_q <= '0;
         skid_q <= '0;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  main_q <= data_in;
                  state  <= BUSY;
               end
            end
            BUSY: begin
               if (accept && take) begin
                  main_q <= data_in;
               end else if (accept) begin
                  skid_q <= data_in;
                  state  <= FULL;
               end else if (take) begin
                  state  <= EMPTY;
               end
            end
            FULL: begin
               if (take) begin
                  main_q <= skid_q;
                  state  <= BUSY;
               end
            end
            default: begin
               state <= EMPTY;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Directed self-checking bench for pipe_skid_buffer: reset, streaming, skid, backpressure, flush, async reset.
module tb_pipe_skid_buffer;

   logic        clk_in;
   logic        reset_n_in;
   logic [31:0] data_in;
   logic        valid_in;
   logic        ready_out;
   logic [31:0] data_out;
   logic        valid_out;
   logic        ready_in;
   logic        flush_in;
   logic [1:0]  occupancy_out;

   int tests_run;
   int tests_failed;

   pipe_skid_buffer #(.BUS_WIDTH(32)) dut (
      .clk_in        (clk_in),
      .reset_n_in    (reset_n_in),
      .data_in       (data_in),
      .valid_in      (valid_in),
      .ready_out     (ready_out),
      .data_out      (data_out),
      .valid_out     (valid_out),
      .ready_in      (ready_in),
      .flush_in      (flush_in),
      .occupancy_out (occupancy_out)
   );

   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   task automatic applyStimulus(input logic v, input logic [31:0] d, input logic rdy, input logic fl);
      valid_in = v;
      data_in  = d;
      ready_in = rdy;
      flush_in = fl;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests_run++;
      assert (observed === expected)
      else begin
         tests_failed++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic checkAll(input string tag, input logic v, input logic [31:0] d,
                           input logic rdy, input logic [1:0] occ);
      checkOutput({tag, ".valid_out"}, {31'd0, valid_out}, {31'd0, v});
      checkOutput({tag, ".data_out"}, data_out, d);
      checkOutput({tag, ".ready_out"}, {31'd0, ready_out}, {31'd0, rdy});
      checkOutput({tag, ".occupancy"}, {30'd0, occupancy_out}, {30'd0, occ});
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;

      // Reset held with a word offered: nothing may be captured.
      reset_n_in = 1'b0;
      applyStimulus(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
      #1;
      checkAll("reset_pre", 1'b0, 32'h0, 1'b1, 2'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkAll("reset_hold", 1'b0, 32'h0, 1'b1, 2'd0);
      end
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      reset_n_in = 1'b1;

      // Streaming with downstream always ready.
      applyStimulus(1'b1, 32'h1, 1'b1, 1'b0);
      tick();
      checkAll("stream1", 1'b1, 32'h1, 1'b1, 2'd1);
      applyStimulus(1'b1, 32'h2, 1'b1, 1'b0);
      tick();
      checkAll("stream2", 1'b1, 32'h2, 1'b1, 2'd1);
      applyStimulus(1'b1, 32'h3, 1'b1, 1'b0);
      tick();
      checkAll("stream3", 1'b1, 32'h3, 1'b1, 2'd1);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      tick();
      checkAll("drain", 1'b0, 32'h3, 1'b1, 2'd0);

      // Stall: second word lands in the skid register.
      applyStimulus(1'b1, 32'hA, 1'b0, 1'b0);
      tick();
      checkAll("stallA", 1'b1, 32'hA, 1'b1, 2'd1);
      applyStimulus(1'b1, 32'hB, 1'b0, 1'b0);
      tick();
      checkAll("stallB", 1'b1, 32'hA, 1'b0, 2'd2);

      // Backpressure: 0xC offered while full must be ignored.
      applyStimulus(1'b1, 32'hC, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         tick();
         checkAll("backpressure", 1'b1, 32'hA, 1'b0, 2'd2);
      end

      // Release: 0xA taken, skid word moves up; 0xC still offered but ready_out was low.
      applyStimulus(1'b1, 32'hC, 1'b1, 1'b0);
      tick();
      checkAll("release", 1'b1, 32'hB, 1'b1, 2'd1);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      tick();
      checkAll("empty_again", 1'b0, 32'hB, 1'b1, 2'd0);

      // Refill to FULL with 0xA, 0xB, then flush with 0xD offered.
      applyStimulus(1'b1, 32'hA, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 32'hB, 1'b0, 1'b0);
      tick();
      checkAll("refill", 1'b1, 32'hA, 1'b0, 2'd2);
      applyStimulus(1'b1, 32'hD, 1'b0, 1'b1);
      tick();
      checkAll("flush", 1'b0, 32'h0, 1'b1, 2'd0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      tick();
      checkAll("post_flush", 1'b0, 32'h0, 1'b1, 2'd0);

      // Async reset between edges while BUSY.
      applyStimulus(1'b1, 32'hE, 1'b0, 1'b0);
      tick();
      checkAll("busyE", 1'b1, 32'hE, 1'b1, 2'd1);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      #2;
      reset_n_in = 1'b0;
      #1;
      checkAll("async_reset", 1'b0, 32'h0, 1'b1, 2'd0);
      tick();
      reset_n_in = 1'b1;

      // First edge after release may accept.
      applyStimulus(1'b1, 32'h5, 1'b1, 1'b0);
      tick();
      checkAll("after_reset", 1'b1, 32'h5, 1'b1, 2'd1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
